// File: rtl/popcount_frame_accum.sv
// Streaming popcount with per-frame saturating accumulation of ones and beats,
// a result handshake, and a registered one-hot popcount of the last accepted word.
module popcount_frame_accum #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int BEAT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_sat,
  output logic [WIDTH:0]    word_onehot
);

  localparam int P_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_acc;
  logic [BEAT_W-1:0]   r_beats;
  logic                r_sat;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_out_count;
  logic [BEAT_W-1:0]   r_out_beats;
  logic                r_out_sat;
  logic [WIDTH:0]      r_onehot;

  logic [P_W-1:0]      w_pop;
  logic [CNT_W:0]      w_acc_sum;
  logic [BEAT_W:0]     w_beat_sum;
  logic [CNT_W-1:0]    w_acc_next;
  logic [BEAT_W-1:0]   w_beats_next;
  logic                w_sat_next;
  logic                w_accept;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + P_W'(in_data[i]);
    end
  end

  // One extra carry bit on each sum doubles as the clamp-hit flag.
  assign w_acc_sum    = {1'b0, r_acc} + (CNT_W + 1)'(w_pop);
  assign w_beat_sum   = {1'b0, r_beats} + (BEAT_W + 1)'(1);
  assign w_acc_next   = w_acc_sum[CNT_W] ? '1 : w_acc_sum[CNT_W-1:0];
  assign w_beats_next = w_beat_sum[BEAT_W] ? '1 : w_beat_sum[BEAT_W-1:0];
  assign w_sat_next   = r_sat | w_acc_sum[CNT_W] | w_beat_sum[BEAT_W];

  assign in_ready    = ena & ~reset & (r_state != S_HOLD);
  assign w_accept    = in_valid & in_ready;

  assign out_valid   = r_out_valid;
  assign out_count   = r_out_count;
  assign out_beats   = r_out_beats;
  assign out_sat     = r_out_sat;
  assign word_onehot = r_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beats     <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
      r_onehot    <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_acc    <= w_acc_next;
            r_beats  <= w_beats_next;
            r_sat    <= w_sat_next;
            r_onehot <= (WIDTH + 1)'(1) << w_pop;
            if (in_last) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_out_count <= w_acc_next;
              r_out_beats <= w_beats_next;
              r_out_sat   <= w_sat_next;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_beats     <= '0;
            r_sat       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Bench for popcount_frame_accum: a default instance and a narrow-counter instance
// share stimulus; a frame-level reference model plus directed tables check both.
module tb_popcount_frame_accum;

  logic       clk = 1'b0;
  logic       reset, ena, in_valid, in_last, out_ready;
  logic [3:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_sat;
  logic [7:0] a_out_count;
  logic [5:0] a_out_beats;
  logic [4:0] a_onehot;

  logic       b_in_ready, b_out_valid, b_out_sat;
  logic [2:0] b_out_count;
  logic [1:0] b_out_beats;
  logic [4:0] b_onehot;

  always #5 clk = ~clk;

  popcount_frame_accum #(.WIDTH(4), .CNT_W(8), .BEAT_W(6)) u_a (
    .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_count(a_out_count), .out_beats(a_out_beats), .out_sat(a_out_sat),
    .word_onehot(a_onehot)
  );

  popcount_frame_accum #(.WIDTH(4), .CNT_W(3), .BEAT_W(2)) u_b (
    .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_count(b_out_count), .out_beats(b_out_beats), .out_sat(b_out_sat),
    .word_onehot(b_onehot)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: list of per-beat popcounts for the open frame.
  int   m_pops[$];
  bit   m_hold, m_ov, m_sat_a, m_sat_b;
  int   m_cnt_a, m_beats_a, m_cnt_b, m_beats_b, m_oh;
  logic g_rdy_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pops.delete();
    m_hold = 0; m_ov = 0; m_sat_a = 0; m_sat_b = 0;
    m_cnt_a = 0; m_beats_a = 0; m_cnt_b = 0; m_beats_b = 0; m_oh = 0;
  endtask

  task automatic model_edge();
    int p, sum, n;
    if (reset) begin
      model_clear();
    end else if (ena) begin
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 0;
          m_ov   = 0;
        end
      end else if (in_valid) begin
        p    = $countones(in_data);
        m_oh = 1 << p;
        m_pops.push_back(p);
        if (in_last) begin
          sum = m_pops.sum();
          n   = m_pops.size();
          m_cnt_a   = (sum > 255) ? 255 : sum;
          m_beats_a = (n > 63) ? 63 : n;
          m_sat_a   = (sum > 255) || (n > 63);
          m_cnt_b   = (sum > 7) ? 7 : sum;
          m_beats_b = (n > 3) ? 3 : n;
          m_sat_b   = (sum > 7) || (n > 3);
          m_hold = 1;
          m_ov   = 1;
          m_pops.delete();
        end
      end
    end
  endtask

  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = ena & ~reset & ~m_hold;
    g_rdy_seen = a_in_ready;
    chk("a_in_ready", 64'(a_in_ready), 64'(exp_rdy));
    chk("b_in_ready", 64'(b_in_ready), 64'(exp_rdy));
    model_edge();
    @(posedge clk);
    #1;
    chk("a_out_valid", 64'(a_out_valid), 64'(m_ov));
    chk("a_out_count", 64'(a_out_count), 64'(m_cnt_a));
    chk("a_out_beats", 64'(a_out_beats), 64'(m_beats_a));
    chk("a_out_sat",   64'(a_out_sat),   64'(m_sat_a));
    chk("a_onehot",    64'(a_onehot),    64'(m_oh));
    chk("b_out_valid", 64'(b_out_valid), 64'(m_ov));
    chk("b_out_count", 64'(b_out_count), 64'(m_cnt_b));
    chk("b_out_beats", 64'(b_out_beats), 64'(m_beats_b));
    chk("b_out_sat",   64'(b_out_sat),   64'(m_sat_b));
    chk("b_onehot",    64'(b_onehot),    64'(m_oh));
  endtask

  task automatic drive(input logic e, input logic v, input logic l, input logic [3:0] d,
                       input logic r);
    reset = 1'b0; ena = e; in_valid = v; in_last = l; in_data = d; out_ready = r;
  endtask

  typedef struct {
    logic       e, v, l, r;
    logic [3:0] d;
    logic       x_rdy;
    logic [4:0] x_oh;
    logic       x_ov;
    int         x_cnt, x_beats;
    logic       x_sat;
  } vec_t;

  vec_t vecs[24];

  initial begin
    //            e  v  l  r  data     rdy oh        ov cnt beats sat
    vecs[0]  = '{1, 1, 0, 0, 4'b1111, 1, 5'b10000, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 4'b0000, 1, 5'b00001, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 4'b1010, 1, 5'b00100, 1, 6, 3, 0};
    vecs[3]  = '{1, 1, 0, 0, 4'b1111, 0, 5'b00100, 1, 6, 3, 0};
    vecs[4]  = '{1, 1, 0, 0, 4'b1111, 0, 5'b00100, 1, 6, 3, 0};
    vecs[5]  = '{1, 1, 0, 0, 4'b1111, 0, 5'b00100, 1, 6, 3, 0};
    vecs[6]  = '{1, 1, 0, 0, 4'b1111, 0, 5'b00100, 1, 6, 3, 0};
    vecs[7]  = '{1, 1, 0, 0, 4'b1111, 0, 5'b00100, 1, 6, 3, 0};
    vecs[8]  = '{1, 1, 0, 1, 4'b1111, 0, 5'b00100, 0, 6, 3, 0};
    vecs[9]  = '{1, 1, 1, 0, 4'b0001, 1, 5'b00010, 1, 1, 1, 0};
    vecs[10] = '{1, 0, 0, 1, 4'b0000, 0, 5'b00010, 0, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 1, 4'b1111, 0, 5'b00010, 0, 1, 1, 0};
    vecs[12] = '{1, 1, 0, 1, 4'b1111, 1, 5'b10000, 0, 1, 1, 0};
    vecs[13] = '{0, 1, 1, 1, 4'b1111, 0, 5'b10000, 0, 1, 1, 0};
    vecs[14] = '{0, 1, 1, 1, 4'b1111, 0, 5'b10000, 0, 1, 1, 0};
    vecs[15] = '{0, 1, 1, 1, 4'b1111, 0, 5'b10000, 0, 1, 1, 0};
    vecs[16] = '{1, 1, 1, 0, 4'b0011, 1, 5'b00100, 1, 6, 2, 0};
    vecs[17] = '{0, 1, 0, 1, 4'b0000, 0, 5'b00100, 1, 6, 2, 0};
    vecs[18] = '{1, 1, 0, 1, 4'b0000, 0, 5'b00100, 0, 6, 2, 0};
    vecs[19] = '{1, 1, 1, 0, 4'b0000, 1, 5'b00001, 1, 0, 1, 0};
    vecs[20] = '{1, 1, 1, 1, 4'b1111, 0, 5'b00001, 0, 0, 1, 0};
    vecs[21] = '{1, 1, 1, 1, 4'b1111, 1, 5'b10000, 1, 4, 1, 0};
    vecs[22] = '{1, 1, 1, 1, 4'b0001, 0, 5'b10000, 0, 4, 1, 0};
    vecs[23] = '{1, 1, 1, 1, 4'b0001, 1, 5'b00010, 1, 1, 1, 0};

    model_clear();
    reset = 1'b1; ena = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 4'hF; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(g_rdy_seen), 64'(0));
    chk("rst_onehot",   64'(a_onehot),   64'(0));
    chk("rst_count",    64'(a_out_count), 64'(0));

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].e, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].r);
      step();
      chk($sformatf("tbl%0d_rdy", i),   64'(g_rdy_seen),  64'(vecs[i].x_rdy));
      chk($sformatf("tbl%0d_oh", i),    64'(a_onehot),    64'(vecs[i].x_oh));
      chk($sformatf("tbl%0d_ov", i),    64'(a_out_valid), 64'(vecs[i].x_ov));
      chk($sformatf("tbl%0d_cnt", i),   64'(a_out_count), 64'(vecs[i].x_cnt));
      chk($sformatf("tbl%0d_beats", i), 64'(a_out_beats), 64'(vecs[i].x_beats));
      chk($sformatf("tbl%0d_sat", i),   64'(a_out_sat),   64'(vecs[i].x_sat));
    end

    // Ones-count saturation on the narrow instance, then a clean frame.
    drive(1, 1, 0, 4'b0000, 1); step();
    drive(1, 1, 0, 4'b1111, 0); step(); step();
    drive(1, 1, 1, 4'b1111, 0); step();
    chk("sat_b_cnt", 64'(b_out_count), 64'(7));
    chk("sat_b_sat", 64'(b_out_sat),   64'(1));
    chk("sat_a_cnt", 64'(a_out_count), 64'(12));
    chk("sat_a_sat", 64'(a_out_sat),   64'(0));
    drive(1, 0, 0, 4'b0000, 1); step();
    drive(1, 1, 1, 4'b0001, 0); step();
    chk("unsat_b_cnt", 64'(b_out_count), 64'(1));
    chk("unsat_b_sat", 64'(b_out_sat),   64'(0));
    drive(1, 0, 0, 4'b0000, 1); step();

    // Beat-count saturation on the narrow instance (max 3 beats).
    drive(1, 1, 0, 4'b0000, 0); step(); step(); step();
    drive(1, 1, 1, 4'b0000, 0); step();
    chk("bsat_b_beats", 64'(b_out_beats), 64'(3));
    chk("bsat_b_sat",   64'(b_out_sat),   64'(1));
    chk("bsat_a_beats", 64'(a_out_beats), 64'(4));
    chk("bsat_a_sat",   64'(a_out_sat),   64'(0));
    drive(1, 0, 0, 4'b0000, 1); step();

    // Mid-frame reset discards partial frame; reset in HOLD drops the result.
    drive(1, 1, 0, 4'b0011, 0); step(); step();
    reset = 1'b1; step();
    drive(1, 1, 1, 4'b0011, 0); step();
    chk("rstmid_cnt",   64'(a_out_count), 64'(2));
    chk("rstmid_beats", 64'(a_out_beats), 64'(1));
    chk("rstmid_ov",    64'(a_out_valid), 64'(1));
    reset = 1'b1; step();
    chk("rsthold_ov", 64'(a_out_valid), 64'(0));
    chk("rsthold_oh", 64'(a_onehot),    64'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 9) < 3);
      in_data   = 4'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
Streaming population counter, the parametrised successor to our fixed 4-input ones-counter. Accepts WIDTH-bit words over a valid/ready handshake and counts the set bits in each word. Accumulates the totals across a frame delimited by in_last, then presents the frame total, beat count and saturation flag on an output handshake. Also gives a registered per-word one-hot popcount for legacy consumers of the 4-input counter's v..z style output.

Parameters:
WIDTH, 4, input word width in bits (>=1)
CNT_W, 8, frame ones-accumulator width (>= clog2(WIDTH+1))
BEAT_W, 6, frame beat-counter width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ena  input  1  global enable; 0 freezes all state
in_valid  input  1  in_data/in_last valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  word to popcount
in_last  input  1  final beat of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_count  output  CNT_W  total set bits in frame (saturating)
out_beats  output  BEAT_W  beats in frame (saturating)
out_sat  output  1  out_count or out_beats saturated during frame
word_onehot  output  WIDTH+1  one-hot popcount of last accepted word; bit k set = k ones

Behaviour:
- Reset (reset=1 at clk edge, overrides ena): state IDLE; acc, beats, sat cleared; out_valid=0, out_count=0, out_beats=0, out_sat=0, word_onehot=0 (all-zero, not "zero ones"). in_ready=0 while reset is high.
- ena=0: no register changes. in_ready=0. out_valid holds its value. out_ready is ignored, so no handoff completes.
- in_ready = ena & ~reset & (state != HOLD). It is combinational from state, not from in_valid.
- Accept = in_valid & in_ready. On accept, p = number of ones in in_data (0..WIDTH):
  - acc <= min(acc + p, 2^CNT_W-1).
  - beats <= min(beats + 1, 2^BEAT_W-1).
  - sat <= sat | (either clamp hit).
  - word_onehot <= (1 << p), visible the cycle after the accept (latency 1). word_onehot holds until the next accept or reset.
- States:
  - IDLE: no beat taken this frame. Accept with in_last=0 -> ACCUM. Accept with in_last=1 -> HOLD.
  - ACCUM: accept with in_last=0 -> ACCUM. Accept with in_last=1 -> HOLD.
  - HOLD: out_valid=1. Registered results include the last beat. On ena & out_ready: out_valid<=0, acc/beats/sat<=0, state -> IDLE.
- Output timing:
  - On the last-beat accept, out_count/out_beats/out_sat load the final values (including that beat) and out_valid rises. All are visible the cycle after the in_last accept (latency 1).
  - out_* stay stable throughout HOLD.
  - After the handoff, out_count/out_beats/out_sat keep their last values until the next frame completes; consumers qualify them with out_valid.
- Throughput and bubbles:
  - One beat per cycle inside a frame.
  - Exactly one bubble per frame: in_ready is low for at least the first HOLD cycle, even if out_ready is already high. The minimum frame period is beats+1 cycles.
  - The in_ready drop is registered via state, so there is no combinational path from out_ready to in_ready.
- Zero-ones words still count as beats. A single-beat frame (in_last on the first beat) is legal.
- Mid-frame reset discards the partial frame. Reset during HOLD drops the undelivered result (out_valid=0 next cycle).
- Saturation is sticky per frame and clears only on handoff or reset.

Test Plan:
- Basic, WIDTH=4: beats 0b1111, 0b0000, 0b1010 (last) -> word_onehot 5'b10000, 5'b00001, 5'b00100 on successive cycles; out_valid=1 with out_count=6, out_beats=3, out_sat=0 one cycle after the last accept.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid and outputs stable, in_ready=0 throughout. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle; the next frame starts from count 0.
- Saturation, CNT_W=3: 3 beats of 0b1111 (last on 3rd) -> out_count=7, out_sat=1. The next frame of one beat 0b0001 -> out_count=1, out_sat=0.
- ena gating: deassert ena mid-frame for 3 cycles with in_valid=1 -> in_ready=0 and no accumulation. Frame total equals the sum of the beats accepted with ena=1 only.
- Reset mid-frame after 2 beats (4 ones), then a new frame of 0b0011 (last) -> out_count=2, out_beats=1. Reset asserted in HOLD -> out_valid=0 next cycle, word_onehot=0.
- Single-beat frame 0b0000 with in_last -> out_count=0, out_beats=1, word_onehot=5'b00001. Back-to-back frames show exactly one bubble cycle.
